add_serial_ctrl: RTL and testbench

- Multi-cycle wide adder that reuses one 8-bit add-with-carry datapath over NBYTES cycles.
- Adds two 8*NBYTES-bit operands plus carry-in, least-significant byte first.
- Carry is held in a register between byte steps.
- Sits between a val/rdy request stream and a val/rdy response stream; used where area matters more than throughput.

---
 rtl/add_serial_pkg.sv | 11 +
 rtl/add_serial_ctrl_add8.sv | 10 +
 rtl/add_serial_ctrl.sv | 72 +++++++
 tb/tb_add_serial_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/add_serial_pkg.sv
// add_serial_pkg: shared state encoding and index sizing for the serial adder
package add_serial_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/add_serial_ctrl_add8.sv
// add8_carry_unit: combinational 8-bit add with carry in and carry out
module add8_carry_unit (
   input  logic [7:0] in0,
   input  logic [7:0] in1,
   input  logic       cin,
   output logic [7:0] out,
   output logic       cout
);
   assign {cout, out} = {1'b0, in0} + {1'b0, in1} + {8'b0, cin};
endmodule

// File: rtl/add_serial_ctrl.sv
// add_serial_ctrl: wide adder that walks one 8-bit carry adder over NBYTES cycles
module add_serial_ctrl
   import add_serial_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                istream_val,
   output logic                istream_rdy,
   input  logic [8*NBYTES-1:0] in0,
   input  logic [8*NBYTES-1:0] in1,
   input  logic                cin,
   output logic                ostream_val,
   input  logic                ostream_rdy,
   output logic [8*NBYTES-1:0] out,
   output logic                cout,
   output logic                busy
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = idx_w(NBYTES);
   state_t state, next_state;
   logic [IW-1:0] idx;
   logic          carry;
   logic [W-1:0]  a, b, res;
   logic [7:0]    a_byte, b_byte, s;
   logic          c, last;
   assign a_byte = a[8*idx +: 8];
   assign b_byte = b[8*idx +: 8];
   assign last   = idx == IW'(NBYTES - 1);
   add8_carry_unit u_add (
      .in0  (a_byte),
      .in1  (b_byte),
      .cin  (carry),
      .out  (s),
      .cout (c)
   );
   // state register
   always_ff @(posedge clk)
      state <= reset ? IDLE : next_state;
   // accept in IDLE, step bytes in CALC, hold the response until taken
   always_comb
      next_state = state == IDLE ? (istream_val ? CALC : IDLE) :
                   state == CALC ? (last ? DONE : CALC) :
                   (ostream_rdy ? IDLE : DONE);
   // handshake and status outputs decoded from the state
   always_comb begin
      istream_rdy = state == IDLE;
      ostream_val = state == DONE;
      busy        = state != IDLE;
   end
   // operand capture, then one result byte and carry update per CALC cycle
   always_ff @(posedge clk)
      if (reset) begin
         idx   <= '0;
         carry <= 1'b0;
         a     <= '0;
         b     <= '0;
         res   <= '0;
      end else if (state == IDLE && istream_val) begin
         a     <= in0;
         b     <= in1;
         carry <= cin;
         idx   <= '0;
      end else if (state == CALC) begin
         res[8*idx +: 8] <= s;
         carry           <= c;
         idx             <= last ? '0 : idx + 1'b1;
      end
   assign out  = res;
   assign cout = carry;
endmodule

// File: tb/tb_add_serial_ctrl.sv
// tb_add_serial_ctrl: directed checks of the serial adder at NBYTES=4 and NBYTES=1
module tb_add_serial_ctrl;
   logic clk = 1'b0, reset = 1'b1;
   logic iv, irdy, ci, ov, ordy, co, bsy;
   logic [31:0] i0, i1, o;
   logic iv1, irdy1, ci1, ov1, ordy1, co1, bsy1;
   logic [7:0] a1, b1, o1;
   int n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;
   add_serial_ctrl #(.NBYTES(4)) dut (
      .clk(clk), .reset(reset), .istream_val(iv), .istream_rdy(irdy),
      .in0(i0), .in1(i1), .cin(ci), .ostream_val(ov), .ostream_rdy(ordy),
      .out(o), .cout(co), .busy(bsy)
   );
   add_serial_ctrl #(.NBYTES(1)) dut1 (
      .clk(clk), .reset(reset), .istream_val(iv1), .istream_rdy(irdy1),
      .in0(a1), .in1(b1), .cin(ci1), .ostream_val(ov1), .ostream_rdy(ordy1),
      .out(o1), .cout(co1), .busy(bsy1)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic run4(input string tag, input logic [31:0] x, input logic [31:0] y, input logic c,
                       input logic [31:0] eo, input logic ec, input bit release_rsp);
      iv = 1'b1; i0 = x; i1 = y; ci = c;
      step();
      iv = 1'b0; i0 = $urandom; i1 = $urandom; ci = 1'($urandom);
      chk({tag, "_rdy_calc"}, irdy, 0);
      chk({tag, "_busy_calc"}, bsy, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk({tag, "_val_early"}, ov, 0);
      end
      step();
      chk({tag, "_val"}, ov, 1);
      chk({tag, "_out"}, o, eo);
      chk({tag, "_cout"}, co, ec);
      if (release_rsp) begin
         ordy = 1'b1;
         step();
         ordy = 1'b0;
         chk({tag, "_idle_rdy"}, irdy, 1);
         chk({tag, "_idle_val"}, ov, 0);
      end
   endtask
   initial begin
      int acc[$];
      iv = 0; ci = 0; ordy = 0; i0 = 0; i1 = 0;
      iv1 = 0; ci1 = 0; ordy1 = 0; a1 = 0; b1 = 0;
      step(); step();
      reset = 1'b0;
      chk("rst_irdy", irdy, 1);
      chk("rst_oval", ov, 0);
      chk("rst_out", o, 0);
      chk("rst_cout", co, 0);
      chk("rst_busy", bsy, 0);
      run4("basic", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1);
      run4("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1);
      chk("hold_out_idle", o, 32'h00000000);
      chk("hold_cout_idle", co, 1);
      run4("mixed", 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1);
      run4("bp", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 0);
      for (int k = 0; k < 7; k++) begin
         step();
         chk("bp_val", ov, 1);
         chk("bp_out", o, 32'h00010000);
         chk("bp_cout", co, 0);
         chk("bp_irdy", irdy, 0);
      end
      ordy = 1'b1;
      step();
      ordy = 1'b0;
      chk("bp_rel_irdy", irdy, 1);
      chk("bp_rel_val", ov, 0);
      run4("after_bp", 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1);
      iv = 1'b1; i0 = 32'hFFFFFFFF; i1 = 32'h1; ci = 1'b0;
      step();
      iv = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_val", ov, 0);
      chk("midrst_irdy", irdy, 1);
      chk("midrst_out", o, 0);
      chk("midrst_cout", co, 0);
      chk("midrst_busy", bsy, 0);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("midrst_no_rsp", ov, 0);
      end
      run4("msb", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1);
      chk("n1_rst_irdy", irdy1, 1);
      iv1 = 1'b1; a1 = 8'hFF; b1 = 8'h01; ci1 = 1'b1;
      step();
      iv1 = 1'b0; a1 = 8'h5A; b1 = 8'hA5; ci1 = 1'b0;
      chk("n1_val_calc", ov1, 0);
      chk("n1_busy", bsy1, 1);
      step();
      chk("n1_val", ov1, 1);
      chk("n1_out", o1, 8'h01);
      chk("n1_cout", co1, 1);
      ordy1 = 1'b1; iv1 = 1'b1; a1 = 8'h01; b1 = 8'h02; ci1 = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (irdy1) acc.push_back(k);
         if (ov1 && k > 0) chk("n1_b2b_out", o1, 8'h03);
         step();
      end
      iv1 = 1'b0; ordy1 = 1'b0;
      chk("n1_accepts", acc.size() >= 4, 1);
      for (int k = 1; k < acc.size(); k++)
         chk("n1_accept_gap", acc[k] - acc[k-1], 3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
